// File: rtl/fht_pkg.sv
`default_nettype none
// Shared FHT types and constants: loader state encoding, bank count, log2 helper.

package fht_pkg;

  localparam int BANKS = 4;

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } loader_state_t;

  function automatic int log2n(input int n);
    return $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fht_bitrev.sv
`default_nettype none
// Combinational bit reversal of a W-bit index; shared by the loader and unloader.

module fht_bitrev #(
  parameter int W = 10
) (
  input  logic [W-1:0] value,
  output logic [W-1:0] reversed
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign reversed[i] = value[W-1-i];
  end

endmodule

`default_nettype wire

// File: rtl/fht_input_loader.sv
`default_nettype none
// Streams N samples into the four data banks in bit-reversed order, then
// hands over to fht_control with a two-cycle start pulse and waits for completion.

module fht_input_loader
  import fht_pkg::*;
#(
  parameter int N     = 1024,
  parameter int D_BIT = 16,
  parameter int A_BIT = log2n(N) - 2,
  parameter int TMO   = 8
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic [D_BIT-1:0] iDATA,
  input  logic             iVALID,
  output logic             oREADY,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic [D_BIT-1:0] oDATA_WR,
  output logic             oWE_0,
  output logic             oWE_1,
  output logic             oWE_2,
  output logic             oWE_3,
  output logic             oSTART,
  input  logic             iFHT_RDY,
  output logic             oBUSY,
  output logic             oERR
);

  localparam int LN = log2n(N);
  localparam int TW = $clog2(TMO + 1);
  localparam logic [LN-1:0] CNT_LAST = LN'(N - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  loader_state_t    state, state_nx;
  logic [LN-1:0]    cnt;
  logic [LN-1:0]    rev;
  logic             start_ph;
  logic [TW-1:0]    tmo;
  logic             ready;
  logic             busy;
  logic             err;
  logic [BANKS-1:0] we;
  logic [A_BIT-1:0] addr;
  logic [D_BIT-1:0] data;
  logic             accept;
  logic             tmo_hit;

  // ready is a register so it stays low while reset is held
  assign accept = iVALID & ready;

  fht_bitrev #(.W(LN)) u_bitrev (
    .value    (cnt),
    .reversed (rev)
  );

  always_comb begin
    state_nx = state;
    tmo_hit  = 1'b0;
    case (state)
      LOAD:      if (accept && cnt == CNT_LAST) state_nx = START;
      START:     if (start_ph) state_nx = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!iFHT_RDY) begin
          state_nx = WAIT_DONE;
        end else if (tmo == TMO_LAST) begin
          tmo_hit  = 1'b1;
          state_nx = LOAD;
        end
      end
      WAIT_DONE: if (iFHT_RDY) state_nx = LOAD;
      default:   state_nx = LOAD;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state    <= LOAD;
      cnt      <= '0;
      start_ph <= 1'b0;
      tmo      <= '0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      we       <= '0;
      addr     <= '0;
      data     <= '0;
    end else begin
      state    <= state_nx;
      ready    <= (state_nx == LOAD);
      err      <= tmo_hit;
      start_ph <= (state == START) && !start_ph;
      tmo      <= (state == WAIT_BUSY) ? tmo + TW'(1) : '0;
      we       <= '0;
      if (accept) begin
        cnt          <= cnt + LN'(1);
        we[rev[1:0]] <= 1'b1;
        addr         <= rev[LN-1:2];
        data         <= iDATA;
      end
      if (accept && cnt == '0) begin
        busy <= 1'b1;
      end else if (tmo_hit || (state == WAIT_DONE && iFHT_RDY)) begin
        busy <= 1'b0;
      end
    end
  end

  // oSTART decodes the async-reset state so a reset aborts the pulse at once
  assign oSTART   = (state == START);
  assign oREADY   = ready;
  assign oBUSY    = busy;
  assign oERR     = err;
  assign oADDR_WR = addr;
  assign oDATA_WR = data;
  assign oWE_0    = we[0];
  assign oWE_1    = we[1];
  assign oWE_2    = we[2];
  assign oWE_3    = we[3];

endmodule

`default_nettype wire

// File: tb/tb_fht_input_loader.sv
`default_nettype none
// Directed bench for fht_input_loader (N=16) with a simple fht_control RDY model.

module tb_fht_input_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic        vld;
  logic        rdy_o;
  logic [1:0]  addr_o;
  logic [15:0] data_o;
  logic        we0, we1, we2, we3;
  logic        start_o;
  logic        fht_rdy = 1'b1;
  logic        busy_o;
  logic        err_o;

  always #5 clk = ~clk;

  fht_input_loader #(.N(16), .D_BIT(16), .A_BIT(2), .TMO(8)) dut (
    .iCLK     (clk),
    .iRESET   (rst),
    .iDATA    (din),
    .iVALID   (vld),
    .oREADY   (rdy_o),
    .oADDR_WR (addr_o),
    .oDATA_WR (data_o),
    .oWE_0    (we0),
    .oWE_1    (we1),
    .oWE_2    (we2),
    .oWE_3    (we3),
    .oSTART   (start_o),
    .iFHT_RDY (fht_rdy),
    .oBUSY    (busy_o),
    .oERR     (err_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor (samples on the falling edge) ----------------
  int wr_n, multi_we, acc_n, first_acc, last_acc;
  int start_n, start_len, start_rise, start_fall, ready_at_rise, busy_at_rise, we_at_rise;
  int err_n, err_cyc;
  int wr_bank[64], wr_addr[64], wr_data[64];
  logic prev_start = 1'b0;

  always @(negedge clk) begin
    logic [3:0] w;
    w = {we3, we2, we1, we0};
    if (w != 4'd0) begin
      if ($countones(w) != 1) multi_we++;
      if (wr_n < 64) begin
        wr_bank[wr_n] = w[1] ? 1 : w[2] ? 2 : w[3] ? 3 : 0;
        wr_addr[wr_n] = int'(addr_o);
        wr_data[wr_n] = int'(data_o);
      end
      wr_n++;
    end
    if (vld && rdy_o) begin
      if (acc_n == 0) first_acc = cyc + 1;
      last_acc = cyc + 1;
      acc_n++;
    end
    if (start_o && !prev_start) begin
      start_n++;
      start_rise    = cyc;
      ready_at_rise = int'(rdy_o);
      busy_at_rise  = int'(busy_o);
      we_at_rise    = int'(w);
    end
    if (start_o) start_len++;
    if (!start_o && prev_start) start_fall = cyc;
    if (err_o) begin
      err_n++;
      err_cyc = cyc;
    end
    prev_start = start_o;
  end

  // ---------------- fht_control RDY model ----------------
  int   rdy_mode = 0;   // 0: drop 3 cycles after start, rise 50 later; 1: never drop
  int   drop_at = -1, rise_at = -1, rdy_rise_cyc = -1;
  logic mdl_prev_start = 1'b0;

  always @(negedge clk) begin
    if (rdy_mode == 0 && start_o && !mdl_prev_start) begin
      drop_at = cyc + 3;
      rise_at = cyc + 53;
    end
    if (cyc == drop_at) fht_rdy = 1'b0;
    if (cyc == rise_at) begin
      fht_rdy      = 1'b1;
      rdy_rise_cyc = cyc;
    end
    mdl_prev_start = start_o;
  end

  // ---------------- helpers ----------------
  typedef struct {
    int idx;
    int bank;
    int addr;
  } vec_t;

  vec_t tab[16];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    wr_n = 0; multi_we = 0; acc_n = 0; start_n = 0; start_len = 0; err_n = 0;
  endtask

  task automatic send_stream(input int count, input int base, input bit gap);
    for (int i = 0; i < count; i++) begin
      int  g;
      bit  acc;
      din = 16'(base + i);
      vld = 1'b1;
      g   = 0;
      forever begin
        acc = rdy_o;
        tick();
        if (acc) break;
        g++;
        if (g > 100) begin
          check("accept_timeout", 0, 1);
          break;
        end
      end
      vld = 1'b0;
      if (gap) tick();
    end
    vld = 1'b0;
  endtask

  task automatic check_table(input string tag, input int base);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s_bank%0d", tag, i), wr_bank[tab[i].idx], tab[i].bank);
      check($sformatf("%s_addr%0d", tag, i), wr_addr[tab[i].idx], tab[i].addr);
      check($sformatf("%s_data%0d", tag, i), wr_data[tab[i].idx], base + tab[i].idx);
    end
  endtask

  task automatic wait_done(input string tag);
    int g = 0;
    while (!rdy_o && g < 200) begin
      tick();
      g++;
    end
    check({tag, "_ready_back"}, int'(rdy_o), 1);
    check({tag, "_ready_cycle"}, cyc, rdy_rise_cyc + 1);
    check({tag, "_busy_clear"}, int'(busy_o), 0);
  endtask

  task automatic check_start(input string tag, input int span);
    check({tag, "_writes"}, wr_n, 16);
    check({tag, "_onehot"}, multi_we, 0);
    check({tag, "_load_span"}, last_acc - first_acc, span);
    check({tag, "_start_lat"}, start_rise, last_acc);
    check({tag, "_start_len"}, start_len, 2);
    check({tag, "_start_cnt"}, start_n, 1);
    check({tag, "_ready_low"}, ready_at_rise, 0);
    check({tag, "_busy_high"}, busy_at_rise, 1);
    check({tag, "_last_we"}, we_at_rise, 8);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tab = '{'{0, 0, 0},  '{1, 0, 2},  '{2, 0, 1},  '{3, 0, 3},
            '{4, 2, 0},  '{5, 2, 2},  '{6, 2, 1},  '{7, 2, 3},
            '{8, 1, 0},  '{9, 1, 2},  '{10, 1, 1}, '{11, 1, 3},
            '{12, 3, 0}, '{13, 3, 2}, '{14, 3, 1}, '{15, 3, 3}};

    rst = 1'b1;
    vld = 1'b0;
    din = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_ready", int'(rdy_o), 0);
    check("rst_start", int'(start_o), 0);
    check("rst_busy",  int'(busy_o), 0);
    check("rst_err",   int'(err_o), 0);
    check("rst_we",    int'({we3, we2, we1, we0}), 0);
    rst = 1'b0;
    check("rel_ready_pre", int'(rdy_o), 0);
    tick();
    check("rel_ready_post", int'(rdy_o), 1);

    // back-to-back stream
    clear_mon();
    send_stream(16, 100, 1'b0);
    wait_done("b2b");
    check_start("b2b", 15);
    check_table("b2b", 100);

    // gapped stream: identical write sequence
    clear_mon();
    send_stream(16, 100, 1'b1);
    wait_done("gap");
    check_start("gap", 30);
    check_table("gap", 100);

    // start timeout: RDY never drops
    rdy_mode = 1;
    clear_mon();
    send_stream(16, 100, 1'b0);
    begin
      int g = 0;
      while (err_n == 0 && g < 100) begin
        tick();
        g++;
      end
      check("tmo_ready", int'(rdy_o), 1);
      check("tmo_busy",  int'(busy_o), 0);
      repeat (12) tick();
      check("tmo_err_cnt", err_n, 1);
      check("tmo_err_delay", err_cyc - start_fall, 8);
    end
    clear_mon();
    send_stream(1, 55, 1'b0);
    repeat (2) tick();
    check("tmo_next_n", wr_n, 1);
    check("tmo_next_bank", wr_bank[0], 0);
    check("tmo_next_addr", wr_addr[0], 0);
    check("tmo_next_data", wr_data[0], 55);

    // reset mid-load, then full reload
    rdy_mode = 0;
    send_stream(7, 150, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    clear_mon();
    send_stream(16, 200, 1'b0);
    repeat (4) tick();
    check("rl_writes", wr_n, 16);
    check("rl_bank0", wr_bank[0], 0);
    check("rl_addr0", wr_addr[0], 0);
    check("rl_data0", wr_data[0], 200);
    check("rl_start_cnt", start_n, 1);
    check("rl_busy", busy_at_rise, 1);

    // valid ignored during WAIT_DONE
    begin
      int g = 0;
      while (fht_rdy && g < 50) begin
        tick();
        g++;
      end
      check("wd_rdy_dropped", int'(fht_rdy), 0);
    end
    tick();
    clear_mon();
    for (int i = 0; i < 30; i++) begin
      vld = 1'b1;
      din = 16'(300 + i);
      tick();
    end
    vld = 1'b0;
    check("wd_no_writes", wr_n, 0);
    check("wd_no_accepts", acc_n, 0);
    wait_done("wd");
    clear_mon();
    send_stream(1, 77, 1'b0);
    repeat (2) tick();
    check("wd_next_bank", wr_bank[0], 0);
    check("wd_next_addr", wr_addr[0], 0);
    check("wd_next_data", wr_data[0], 77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
